// File: rtl/seg_pkg.sv
// Shared seven-segment code constants and scan-decoder FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seg_pkg;

   // Segment codes, bit0 = a ... bit6 = g, active-high
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_A     = 7'h77;
   localparam logic [6:0] SEG_B     = 7'h7C;
   localparam logic [6:0] SEG_C     = 7'h39;
   localparam logic [6:0] SEG_D     = 7'h5E;
   localparam logic [6:0] SEG_E     = 7'h79;
   localparam logic [6:0] SEG_F     = 7'h71;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Scan FSM: IDLE = no usable select, SETTLE = one-hot select counting,
   // HOLD = digit captured, waiting for the sample to move
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } scan_state_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Seven-segment code to hex nibble lookup with recognised-pattern flag.
// Latency: combinational.
// Backpressure: none.
module seg7_to_hex
   import seg_pkg::*;
(
   input  logic [6:0] code,
   output logic [3:0] nibble,
   output logic       valid
);

   // Unrecognised codes (blank included) decode to 0 with valid low
   always_comb begin
      nibble = 4'h0;
      valid  = 1'b1;
      case (code)
         SEG_0:   nibble = 4'h0;
         SEG_1:   nibble = 4'h1;
         SEG_2:   nibble = 4'h2;
         SEG_3:   nibble = 4'h3;
         SEG_4:   nibble = 4'h4;
         SEG_5:   nibble = 4'h5;
         SEG_6:   nibble = 4'h6;
         SEG_7:   nibble = 4'h7;
         SEG_8:   nibble = 4'h8;
         SEG_9:   nibble = 4'h9;
         SEG_A:   nibble = 4'hA;
         SEG_B:   nibble = 4'hB;
         SEG_C:   nibble = 4'hC;
         SEG_D:   nibble = 4'hD;
         SEG_E:   nibble = 4'hE;
         SEG_F:   nibble = 4'hF;
         default: valid  = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Rebuilds hex digits from a scanned seven-segment bus; pulses once per full frame.
// Latency: capture STABLE_CYCLES+1 edges after an input lands in sync stage 1.
// Backpressure: none; frame_valid and sel_error are single-cycle pulses.
module seg_scan_decoder
   import seg_pkg::*;
#(
   parameter int DIGITS         = 4,
   parameter int STABLE_CYCLES  = 8,
   parameter bit SEG_ACTIVE_LOW = 1'b0,
   parameter bit SEL_ACTIVE_LOW = 1'b0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [6:0]            segment_in,
   input  logic [DIGITS-1:0]     bytee_in,
   output logic [4*DIGITS-1:0]   digits_out,
   output logic [DIGITS-1:0]     digit_valid,
   output logic                  frame_valid,
   output logic                  sel_error
);

   // Counter value that, when unchanged for one more edge, completes the stable period
   localparam logic [7:0] CNT_PRE = 8'(STABLE_CYCLES - 2);
   localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

   logic [6:0]          seg_s1, seg_s2;
   logic [DIGITS-1:0]   sel_s1, sel_s2;
   logic [6:0]          seg_v;
   logic [DIGITS-1:0]   sel_v;
   logic [DIGITS+6:0]   prev_s;
   logic                changed;
   logic [7:0]          cnt;
   logic                sel_onehot;
   logic                sel_multi;

   scan_state_t         state, state_nxt;
   logic                capture;
   logic                sel_err_nxt;

   logic [3:0]          dec_nib;
   logic                dec_vld;

   logic [4*DIGITS-1:0] shadow_nib, shadow_nib_nxt;
   logic [DIGITS-1:0]   shadow_vld, shadow_vld_nxt;
   logic [DIGITS-1:0]   seen, seen_nxt;
   logic                frame_done;

   // Two-stage synchronizer on the asynchronous display lines
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         seg_s1 <= '0;
         seg_s2 <= '0;
         sel_s1 <= '0;
         sel_s2 <= '0;
      end else begin
         seg_s1 <= segment_in;
         seg_s2 <= seg_s1;
         sel_s1 <= bytee_in;
         sel_s2 <= sel_s1;
      end
   end

   assign seg_v      = seg_s2 ^ {7{SEG_ACTIVE_LOW}};
   assign sel_v      = sel_s2 ^ {DIGITS{SEL_ACTIVE_LOW}};
   assign changed    = ({sel_v, seg_v} != prev_s);
   assign sel_onehot = (sel_v != '0) && ((sel_v & (sel_v - DIGITS'(1))) == '0);
   assign sel_multi  = (sel_v != '0) && !sel_onehot;

   // Stability counter: restarts on any sample change, saturates at the last count
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         prev_s <= '0;
         cnt    <= '0;
      end else begin
         prev_s <= {sel_v, seg_v};
         if (changed)
            cnt <= '0;
         else if (cnt != CNT_MAX)
            cnt <= cnt + 8'd1;
      end
   end

   // FSM state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next state, capture strobe and select-error strobe
   always_comb begin
      state_nxt   = state;
      capture     = 1'b0;
      sel_err_nxt = 1'b0;
      if (changed) begin
         state_nxt = sel_onehot ? SETTLE : IDLE;
      end else begin
         case (state)
            IDLE:    if (cnt == CNT_PRE && sel_multi) sel_err_nxt = 1'b1;
            SETTLE:  if (cnt == CNT_PRE) begin
                        state_nxt = HOLD;
                        capture   = 1'b1;
                     end
            HOLD:    state_nxt = HOLD;
            default: state_nxt = IDLE;
         endcase
      end
   end

   seg7_to_hex u_dec (
      .code   (seg_v),
      .nibble (dec_nib),
      .valid  (dec_vld)
   );

   // Shadow update for the selected digit; a repeat capture simply overwrites
   always_comb begin
      shadow_nib_nxt = shadow_nib;
      shadow_vld_nxt = shadow_vld;
      seen_nxt       = seen;
      if (capture) begin
         for (int i = 0; i < DIGITS; i++) begin
            if (sel_v[i]) begin
               shadow_nib_nxt[4*i +: 4] = dec_nib;
               shadow_vld_nxt[i]        = dec_vld;
            end
         end
         seen_nxt = seen | sel_v;
      end
   end

   assign frame_done = capture && (seen_nxt == '1);

   // Shadows, seen mask and published frame; completion publishes and restarts the mask
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         shadow_nib  <= '0;
         shadow_vld  <= '0;
         seen        <= '0;
         digits_out  <= '0;
         digit_valid <= '0;
         frame_valid <= 1'b0;
         sel_error   <= 1'b0;
      end else begin
         shadow_nib  <= shadow_nib_nxt;
         shadow_vld  <= shadow_vld_nxt;
         frame_valid <= frame_done;
         sel_error   <= sel_err_nxt;
         if (frame_done) begin
            digits_out  <= shadow_nib_nxt;
            digit_valid <= shadow_vld_nxt;
            seen        <= '0;
         end else begin
            seen <= seen_nxt;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with a frame scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_seg_scan_decoder;
   import seg_pkg::*;

   typedef struct packed {
      logic [15:0] dig;
      logic [3:0]  vld;
   } frame_t;

   logic        clock = 1'b0;
   logic        reset;
   logic [6:0]  segment_in;
   logic [3:0]  bytee_in;
   logic [15:0] digits_out;
   logic [3:0]  digit_valid;
   logic        frame_valid;
   logic        sel_error;

   int checks = 0;
   int errors = 0;
   int fv_cnt = 0;
   int se_cnt = 0;
   int cyc = 0;
   int last_fv_cyc = -1;
   frame_t exp_q[$];
   frame_t mon_f;

   always #5 clock = ~clock;

   seg_scan_decoder #(
      .DIGITS         (4),
      .STABLE_CYCLES  (8),
      .SEG_ACTIVE_LOW (1'b0),
      .SEL_ACTIVE_LOW (1'b0)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .segment_in  (segment_in),
      .bytee_in    (bytee_in),
      .digits_out  (digits_out),
      .digit_valid (digit_valid),
      .frame_valid (frame_valid),
      .sel_error   (sel_error)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   function automatic frame_t mk(input logic [15:0] dig, input logic [3:0] vld);
      frame_t f;
      f.dig = dig;
      f.vld = vld;
      return f;
   endfunction

   // Drive one select/segment pair for n cycles; entered and left at posedge+1
   task automatic hold(input logic [3:0] sel, input logic [6:0] seg, input int n);
      bytee_in   = sel;
      segment_in = seg;
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_digits"}, digits_out, 32'h0);
      check({tag, "_valid"}, digit_valid, 32'h0);
      check({tag, "_frame_valid"}, frame_valid, 32'h0);
      check({tag, "_sel_error"}, sel_error, 32'h0);
   endtask

   always @(posedge clock) cyc <= cyc + 1;

   // Scoreboard: every frame pulse pops the oldest expected frame
   always @(negedge clock) begin
      if (reset && frame_valid) begin
         fv_cnt++;
         last_fv_cyc = cyc;
         check("frame_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            mon_f = exp_q.pop_front();
            check("frame_digits", digits_out, 32'(mon_f.dig));
            check("frame_digit_valid", digit_valid, 32'(mon_f.vld));
         end
      end
      if (reset && sel_error) se_cnt++;
   end

   initial begin
      int fv0;
      int se0;
      int c0;

      reset      = 1'b0;
      segment_in = '0;
      bytee_in   = '0;
      repeat (3) begin
         @(posedge clock);
         #1;
      end
      check_reset_outputs("por");
      reset = 1'b1;
      hold(4'b0000, SEG_BLANK, 5);

      // Normal scan 1,2,3,4, two loops
      for (int l = 0; l < 2; l++) begin
         fv0 = fv_cnt;
         exp_q.push_back(mk(16'h4321, 4'hF));
         hold(4'b0001, SEG_1, 20);
         hold(4'b0010, SEG_2, 20);
         hold(4'b0100, SEG_3, 20);
         hold(4'b1000, SEG_4, 20);
         check("scan_loop_frames", fv_cnt - fv0, 1);
         check("scan_digits", digits_out, 32'h4321);
         check("scan_valid", digit_valid, 32'hF);
      end

      // Short glitch on the last digit must not capture nor touch the mask
      fv0 = fv_cnt;
      hold(4'b0001, SEG_A, 20);
      hold(4'b0010, SEG_B, 20);
      hold(4'b0100, SEG_C, 20);
      hold(4'b1000, SEG_9, 5);
      hold(4'b0000, SEG_BLANK, 20);
      check("short_hold_no_frame", fv_cnt - fv0, 0);
      exp_q.push_back(mk(16'h7CBA, 4'hF));
      hold(4'b1000, SEG_7, 20);
      check("short_hold_then_frame", fv_cnt - fv0, 1);

      // Multi-hot select: one error pulse, nothing captured
      fv0 = fv_cnt;
      se0 = se_cnt;
      hold(4'b0011, SEG_1, 20);
      check("multi_hot_sel_error", se_cnt - se0, 1);
      check("multi_hot_no_frame", fv_cnt - fv0, 0);
      hold(4'b0000, SEG_BLANK, 5);
      // Order 2,3,0,1: a stray capture of digits 0/1 would complete the frame early
      exp_q.push_back(mk(16'h0000, 4'b1011));
      hold(4'b0100, SEG_BLANK, 20);
      hold(4'b1000, SEG_0, 20);
      hold(4'b0001, SEG_0, 20);
      hold(4'b0010, SEG_0, 20);
      check("blank_frame_count", fv_cnt - fv0, 1);
      check("blank_frame_valid_mask", digit_valid, 32'hB);

      // Reset mid-frame discards the partial frame
      hold(4'b0001, SEG_5, 20);
      hold(4'b0010, SEG_5, 20);
      reset      = 1'b0;
      bytee_in   = '0;
      segment_in = '0;
      repeat (3) begin
         @(posedge clock);
         #1;
      end
      check_reset_outputs("mid_reset");
      reset = 1'b1;
      hold(4'b0000, SEG_BLANK, 5);
      fv0 = fv_cnt;
      exp_q.push_back(mk(16'h6789, 4'hF));
      hold(4'b1000, SEG_6, 20);
      hold(4'b0100, SEG_7, 20);
      hold(4'b0001, SEG_9, 20);
      hold(4'b0010, SEG_8, 20);
      check("post_reset_frames", fv_cnt - fv0, 1);

      // Long static input: single capture, no frame, no error
      fv0 = fv_cnt;
      se0 = se_cnt;
      hold(4'b0001, SEG_1, 1000);
      check("static_no_frame", fv_cnt - fv0, 0);
      check("static_no_sel_error", se_cnt - se0, 0);
      exp_q.push_back(mk(16'hFED1, 4'hF));
      hold(4'b1000, SEG_F, 20);
      hold(4'b0100, SEG_E, 20);
      c0 = cyc;
      hold(4'b0010, SEG_D, 20);
      check("static_then_frame", fv_cnt - fv0, 1);
      check("capture_latency", last_fv_cyc, c0 + 10);

      hold(4'b0000, SEG_BLANK, 10);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
